// File: rtl/ra_bus_arb_pkg.sv
// ra_bus_arb_pkg
//   Shared bus geometry for the two-master arbiter and the request record
//   that each master's pending slot holds between capture and issue.
//   No ports. Provides ADDR_W, DATA_W, BE_W and bus_req_t.
package ra_bus_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // One captured master request, exactly what gets driven onto the b_* bus.
  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } bus_req_t;

endpackage

// File: rtl/ra_bus_arb_slot.sv
// ra_bus_arb_slot
//   Per-master pending slot. Captures a one-cycle read/write strobe, holds it
//   until the arbiter takes it, and flags protocol violations.
// Ports:
//   clk, reset_l_in      clock, async active-low reset
//   re, we               master read/write strobes (one-cycle pulses)
//   addr, wdata, be      request fields, valid with the strobe
//   busy                 this master has a transaction outstanding on the bus
//   take                 arbiter issues this slot's request at the coming edge
//   req_valid            a request is available (stored, or accepted this cycle)
//   req                  the request on offer (stored copy, else the live strobe)
//   viol                 sticky violation flag, cleared only by reset
module ra_bus_arb_slot
  import ra_bus_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset_l_in,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  input  logic              busy,
  input  logic              take,
  output logic              req_valid,
  output bus_req_t          req,
  output logic              viol
);

  logic     valid_q;
  bus_req_t slot_q;
  bus_req_t incoming;
  logic     strobe;
  logic     accept;
  logic     viol_set;

  // A strobe is only accepted into an empty slot when the master has nothing
  // in flight. The live strobe is also offered to the arbiter directly so an
  // idle arbiter can put it on the bus one cycle after the strobe.
  always_comb begin
    incoming.is_write = we;
    incoming.addr     = addr;
    incoming.wdata    = wdata;
    incoming.be       = be;
    strobe    = re | we;
    accept    = strobe & ~valid_q & ~busy;
    viol_set  = (re & we) | (strobe & (valid_q | busy));
    req_valid = valid_q | accept;
    req       = valid_q ? slot_q : incoming;
  end

  // When the request is taken in the same cycle it arrives, it goes straight
  // to the bus and never needs to be stored.
  always_ff @(posedge clk or negedge reset_l_in) begin
    if (!reset_l_in) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
      viol    <= 1'b0;
    end else begin
      if (take) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        slot_q  <= incoming;
      end
      if (viol_set) begin
        viol <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ra_bus_arb.sv
// ra_bus_arb
//   Two-master round-robin bus arbiter. Master 0 is the CPU, master 1 a second
//   master (DMA / debug bridge). Requests are issued one at a time; the slave's
//   ack and read data are routed back to the owner, and an error ack with
//   ERR_DATA is returned if the slave does not answer within TIMEOUT cycles.
// Parameters:
//   TIMEOUT   cycles to wait for a slave ack after issue (2..255)
//   ERR_DATA  read data returned on a timed-out access
// Ports:
//   clk, reset_l_in                 clock, async active-low reset
//   mN_re, mN_we                    master strobes (one-cycle pulses)
//   mN_addr, mN_wdata, mN_be        master request fields
//   mN_rdata, mN_ack, mN_err        master completion (ack is a one-cycle pulse)
//   viol                            sticky protocol-violation flag
//   b_re, b_we, b_addr, b_wdata, b_be   bus request outputs
//   b_rdata, b_rd_ack, b_wr_ack     slave response inputs
module ra_bus_arb
  import ra_bus_arb_pkg::*;
#(
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset_l_in,
  input  logic              m0_re,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [BE_W-1:0]   m0_be,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_re,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [BE_W-1:0]   m1_be,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              viol,
  output logic              b_re,
  output logic              b_we,
  output logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_wdata,
  output logic [BE_W-1:0]   b_be,
  input  logic [DATA_W-1:0] b_rdata,
  input  logic              b_rd_ack,
  input  logic              b_wr_ack
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q;
  state_t      state_d;
  logic        owner_q;
  logic        prio_q;
  logic        is_wr_q;
  logic [7:0]  cnt_q;

  logic        req0_valid;
  logic        req1_valid;
  bus_req_t    req0;
  bus_req_t    req1;
  bus_req_t    sel_req;
  logic        viol0;
  logic        viol1;
  logic        busy0;
  logic        busy1;
  logic        take0;
  logic        take1;

  logic        issue;
  logic        grant;
  logic        done;
  logic        timed_out;
  logic        slave_ack;
  logic [DATA_W-1:0] ret_data;

  assign busy0 = (state_q == S_WAIT) & ~owner_q;
  assign busy1 = (state_q == S_WAIT) &  owner_q;
  assign take0 = issue & ~grant;
  assign take1 = issue &  grant;
  assign viol  = viol0 | viol1;

  ra_bus_arb_slot u_slot0 (
    .clk        (clk),
    .reset_l_in (reset_l_in),
    .re         (m0_re),
    .we         (m0_we),
    .addr       (m0_addr),
    .wdata      (m0_wdata),
    .be         (m0_be),
    .busy       (busy0),
    .take       (take0),
    .req_valid  (req0_valid),
    .req        (req0),
    .viol       (viol0)
  );

  ra_bus_arb_slot u_slot1 (
    .clk        (clk),
    .reset_l_in (reset_l_in),
    .re         (m1_re),
    .we         (m1_we),
    .addr       (m1_addr),
    .wdata      (m1_wdata),
    .be         (m1_be),
    .busy       (busy1),
    .take       (take1),
    .req_valid  (req1_valid),
    .req        (req1),
    .viol       (viol1)
  );

  always_ff @(posedge clk or negedge reset_l_in) begin
    if (!reset_l_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Acks seen in IDLE are simply never looked at, which is how stale or late
  // slave acks get discarded. In WAIT an ack takes precedence over the
  // timeout when both land on the same cycle.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    grant     = 1'b0;
    done      = 1'b0;
    timed_out = 1'b0;
    slave_ack = b_rd_ack | b_wr_ack;
    case (state_q)
      S_IDLE: begin
        if (req0_valid | req1_valid) begin
          issue   = 1'b1;
          grant   = (req0_valid & req1_valid) ? prio_q : req1_valid;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (slave_ack) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          done      = 1'b1;
          timed_out = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    sel_req = grant ? req1 : req0;
    if (timed_out) begin
      ret_data = ERR_DATA;
    end else if (is_wr_q) begin
      ret_data = '0;
    end else begin
      ret_data = b_rdata;
    end
  end

  // Bus strobes and master acks are single-cycle pulses; address/data and
  // returned read data hold their last values between pulses.
  always_ff @(posedge clk or negedge reset_l_in) begin
    if (!reset_l_in) begin
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      is_wr_q  <= 1'b0;
      cnt_q    <= '0;
      b_re     <= 1'b0;
      b_we     <= 1'b0;
      b_addr   <= '0;
      b_wdata  <= '0;
      b_be     <= '0;
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
    end else begin
      b_re   <= 1'b0;
      b_we   <= 1'b0;
      m0_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_ack <= 1'b0;
      m1_err <= 1'b0;
      if (issue) begin
        b_re    <= ~sel_req.is_write;
        b_we    <=  sel_req.is_write;
        b_addr  <=  sel_req.addr;
        b_wdata <=  sel_req.wdata;
        b_be    <=  sel_req.be;
        owner_q <=  grant;
        is_wr_q <=  sel_req.is_write;
        cnt_q   <= '0;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (done) begin
        prio_q <= ~owner_q;
        if (owner_q) begin
          m1_ack   <= 1'b1;
          m1_err   <= timed_out;
          m1_rdata <= ret_data;
        end else begin
          m0_ack   <= 1'b1;
          m0_err   <= timed_out;
          m0_rdata <= ret_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_ra_bus_arb.sv
// tb_ra_bus_arb
//   Directed bench for ra_bus_arb: one instance at the default TIMEOUT and one
//   at TIMEOUT = 4 for the ack-versus-timeout boundary. Inputs change 1 ns
//   after the rising edge; outputs are read at the same point.
module tb_ra_bus_arb;

  logic        clk = 1'b0;
  logic        reset_l_in;

  logic        m0_re, m0_we, m1_re, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err, viol;
  logic        b_re, b_we;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;
  logic        b_rd_ack, b_wr_ack;

  logic        t4_m0_re, t4_m0_we, t4_m1_re, t4_m1_we;
  logic [31:0] t4_m0_addr, t4_m0_wdata, t4_m1_addr, t4_m1_wdata;
  logic [3:0]  t4_m0_be, t4_m1_be;
  logic [31:0] t4_m0_rdata, t4_m1_rdata;
  logic        t4_m0_ack, t4_m0_err, t4_m1_ack, t4_m1_err, t4_viol;
  logic        t4_b_re, t4_b_we;
  logic [31:0] t4_b_addr, t4_b_wdata, t4_b_rdata;
  logic [3:0]  t4_b_be;
  logic        t4_b_rd_ack, t4_b_wr_ack;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ra_bus_arb dut (
    .clk (clk), .reset_l_in (reset_l_in),
    .m0_re (m0_re), .m0_we (m0_we), .m0_addr (m0_addr), .m0_wdata (m0_wdata), .m0_be (m0_be),
    .m0_rdata (m0_rdata), .m0_ack (m0_ack), .m0_err (m0_err),
    .m1_re (m1_re), .m1_we (m1_we), .m1_addr (m1_addr), .m1_wdata (m1_wdata), .m1_be (m1_be),
    .m1_rdata (m1_rdata), .m1_ack (m1_ack), .m1_err (m1_err),
    .viol (viol),
    .b_re (b_re), .b_we (b_we), .b_addr (b_addr), .b_wdata (b_wdata), .b_be (b_be),
    .b_rdata (b_rdata), .b_rd_ack (b_rd_ack), .b_wr_ack (b_wr_ack)
  );

  ra_bus_arb #(.TIMEOUT(4)) dut4 (
    .clk (clk), .reset_l_in (reset_l_in),
    .m0_re (t4_m0_re), .m0_we (t4_m0_we), .m0_addr (t4_m0_addr), .m0_wdata (t4_m0_wdata), .m0_be (t4_m0_be),
    .m0_rdata (t4_m0_rdata), .m0_ack (t4_m0_ack), .m0_err (t4_m0_err),
    .m1_re (t4_m1_re), .m1_we (t4_m1_we), .m1_addr (t4_m1_addr), .m1_wdata (t4_m1_wdata), .m1_be (t4_m1_be),
    .m1_rdata (t4_m1_rdata), .m1_ack (t4_m1_ack), .m1_err (t4_m1_err),
    .viol (t4_viol),
    .b_re (t4_b_re), .b_we (t4_b_we), .b_addr (t4_b_addr), .b_wdata (t4_b_wdata), .b_be (t4_b_be),
    .b_rdata (t4_b_rdata), .b_rd_ack (t4_b_rd_ack), .b_wr_ack (t4_b_wr_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one strobe on master 0 or 1 of the default-TIMEOUT instance.
  task automatic applyStimulus(input int master, input logic re, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be);
    if (master == 0) begin
      m0_re = re; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
    end else begin
      m1_re = re; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
    end
  endtask

  task automatic clearStrobes();
    m0_re = 1'b0; m0_we = 1'b0; m1_re = 1'b0; m1_we = 1'b0;
    b_rd_ack = 1'b0; b_wr_ack = 1'b0;
    t4_m0_re = 1'b0; t4_m0_we = 1'b0; t4_m1_re = 1'b0; t4_m1_we = 1'b0;
    t4_b_rd_ack = 1'b0; t4_b_wr_ack = 1'b0;
  endtask

  initial begin
    int n;
    reset_l_in = 1'b0;
    clearStrobes();
    m0_addr = '0; m0_wdata = '0; m0_be = '0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    b_rdata = '0;
    t4_m0_addr = '0; t4_m0_wdata = '0; t4_m0_be = '0;
    t4_m1_addr = '0; t4_m1_wdata = '0; t4_m1_be = '0;
    t4_b_rdata = 32'h9999_9999;
    repeat (3) tick();

    checkOutput("reset b_re", b_re, 0);
    checkOutput("reset b_addr", b_addr, 0);
    checkOutput("reset m0_ack", m0_ack, 0);
    checkOutput("reset m0_rdata", m0_rdata, 0);
    checkOutput("reset viol", viol, 0);
    reset_l_in = 1'b1;
    tick();

    // Single read from m0, slave answers 3 cycles after b_re.
    applyStimulus(0, 1, 0, 32'h0001_0000, 32'h0, 4'hF);
    tick();
    clearStrobes();
    checkOutput("rd b_re", b_re, 1);
    checkOutput("rd b_we", b_we, 0);
    checkOutput("rd b_addr", b_addr, 32'h0001_0000);
    tick(); tick(); tick();
    checkOutput("rd no early ack", m0_ack, 0);
    b_rd_ack = 1'b1; b_rdata = 32'h1234_5678;
    tick();
    clearStrobes();
    checkOutput("rd m0_ack", m0_ack, 1);
    checkOutput("rd m0_rdata", m0_rdata, 32'h1234_5678);
    checkOutput("rd m0_err", m0_err, 0);
    checkOutput("rd m1_ack", m1_ack, 0);
    tick();
    checkOutput("rd ack pulse", m0_ack, 0);
    checkOutput("rd rdata hold", m0_rdata, 32'h1234_5678);

    // Reset asserted while a read is outstanding.
    applyStimulus(0, 1, 0, 32'h0000_0010, 32'h0, 4'hF);
    tick();
    clearStrobes();
    checkOutput("mid b_re", b_re, 1);
    tick();
    reset_l_in = 1'b0;
    #1;
    checkOutput("mid async b_addr", b_addr, 0);
    checkOutput("mid async m0_rdata", m0_rdata, 0);
    tick();
    reset_l_in = 1'b1;
    b_rd_ack = 1'b1; b_rdata = 32'h5555_5555;
    tick();
    clearStrobes();
    checkOutput("stale ack m0_ack", m0_ack, 0);
    checkOutput("stale ack b_re", b_re, 0);
    applyStimulus(0, 1, 0, 32'h0000_0020, 32'h0, 4'hF);
    tick();
    clearStrobes();
    checkOutput("post-reset b_addr", b_addr, 32'h0000_0020);
    b_rd_ack = 1'b1; b_rdata = 32'hABCD_0001;
    tick();
    clearStrobes();
    checkOutput("post-reset m0_ack", m0_ack, 1);
    checkOutput("post-reset m0_rdata", m0_rdata, 32'hABCD_0001);

    // Fresh reset so the priority pointer favours m0 again.
    reset_l_in = 1'b0;
    tick();
    reset_l_in = 1'b1;
    tick();

    // Simultaneous pair: m0 read and m1 write; m0 goes first.
    applyStimulus(0, 1, 0, 32'h0000_2000, 32'h0, 4'hF);
    applyStimulus(1, 0, 1, 32'h0300_0000, 32'h0000_00A5, 4'h1);
    tick();
    clearStrobes();
    checkOutput("pair1 first b_re", b_re, 1);
    checkOutput("pair1 first b_addr", b_addr, 32'h0000_2000);
    b_rd_ack = 1'b1; b_rdata = 32'h1111_2222;
    tick();
    clearStrobes();
    checkOutput("pair1 m0_ack", m0_ack, 1);
    checkOutput("pair1 m0_rdata", m0_rdata, 32'h1111_2222);
    checkOutput("pair1 gap b_we", b_we, 0);
    tick();
    checkOutput("pair1 second b_we", b_we, 1);
    checkOutput("pair1 second b_re", b_re, 0);
    checkOutput("pair1 second b_addr", b_addr, 32'h0300_0000);
    checkOutput("pair1 second b_wdata", b_wdata, 32'h0000_00A5);
    checkOutput("pair1 second b_be", b_be, 4'h1);
    b_wr_ack = 1'b1;
    tick();
    clearStrobes();
    checkOutput("pair1 m1_ack", m1_ack, 1);
    checkOutput("pair1 m1_err", m1_err, 0);
    checkOutput("pair1 m1_rdata write zero", m1_rdata, 32'h0);

    // A lone m0 access hands priority to m1 for the next pair.
    applyStimulus(0, 1, 0, 32'h0000_0004, 32'h0, 4'hF);
    tick();
    clearStrobes();
    b_rd_ack = 1'b1; b_rdata = 32'h0000_0044;
    tick();
    clearStrobes();
    checkOutput("lone m0_ack", m0_ack, 1);

    applyStimulus(0, 0, 1, 32'h0000_5000, 32'h0000_0077, 4'hF);
    applyStimulus(1, 1, 0, 32'h0000_6000, 32'h0, 4'hF);
    tick();
    clearStrobes();
    checkOutput("pair2 first b_re", b_re, 1);
    checkOutput("pair2 first b_addr", b_addr, 32'h0000_6000);
    b_rd_ack = 1'b1; b_rdata = 32'hCAFE_F00D;
    tick();
    clearStrobes();
    checkOutput("pair2 m1_ack", m1_ack, 1);
    checkOutput("pair2 m1_rdata", m1_rdata, 32'hCAFE_F00D);
    checkOutput("pair2 m0 not acked", m0_ack, 0);
    tick();
    checkOutput("pair2 second b_we", b_we, 1);
    checkOutput("pair2 second b_addr", b_addr, 32'h0000_5000);
    checkOutput("pair2 second b_wdata", b_wdata, 32'h0000_0077);
    checkOutput("pair2 second b_be", b_be, 4'hF);
    b_wr_ack = 1'b1;
    tick();
    clearStrobes();
    checkOutput("pair2 m0_ack", m0_ack, 1);
    checkOutput("pair2 m0_rdata write zero", m0_rdata, 32'h0);
    checkOutput("legal traffic viol", viol, 0);

    // Timeout on m1 to an unmapped address, then a late ack while idle.
    applyStimulus(1, 1, 0, 32'hF000_0000, 32'h0, 4'hF);
    tick();
    clearStrobes();
    checkOutput("to b_re", b_re, 1);
    n = 0;
    while (m1_ack !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checkOutput("to latency", n, 256);
    checkOutput("to m1_err", m1_err, 1);
    checkOutput("to m1_rdata", m1_rdata, 32'hDEAD_BEEF);
    checkOutput("to m0_ack", m0_ack, 0);
    b_rd_ack = 1'b1; b_rdata = 32'h7777_7777;
    tick();
    clearStrobes();
    checkOutput("late ack m1_ack", m1_ack, 0);
    checkOutput("late ack m1_err", m1_err, 0);
    checkOutput("late ack m0_ack", m0_ack, 0);

    // Second m0 strobe before its ack is ignored and flagged.
    applyStimulus(0, 1, 0, 32'h0000_0100, 32'h0, 4'hF);
    tick();
    checkOutput("viol first b_re", b_re, 1);
    applyStimulus(0, 1, 0, 32'h0000_0200, 32'h0, 4'hF);
    tick();
    clearStrobes();
    checkOutput("viol set", viol, 1);
    checkOutput("viol no second issue", b_re, 0);
    b_rd_ack = 1'b1; b_rdata = 32'h0000_0100;
    tick();
    clearStrobes();
    checkOutput("viol m0_ack", m0_ack, 1);
    checkOutput("viol idle b_re", b_re, 0);
    tick();
    checkOutput("viol dropped request", b_re, 0);
    tick();
    checkOutput("viol sticky", viol, 1);

    // TIMEOUT = 4: ack landing when the counter reaches 4 is a normal ack.
    t4_m0_we = 1'b1; t4_m0_addr = 32'h0000_0100; t4_m0_wdata = 32'h55; t4_m0_be = 4'h3;
    tick();
    clearStrobes();
    checkOutput("t4 b_we", t4_b_we, 1);
    repeat (4) tick();
    checkOutput("t4 no early ack", t4_m0_ack, 0);
    t4_b_wr_ack = 1'b1;
    tick();
    clearStrobes();
    checkOutput("t4 boundary m0_ack", t4_m0_ack, 1);
    checkOutput("t4 boundary m0_err", t4_m0_err, 0);
    checkOutput("t4 boundary m0_rdata", t4_m0_rdata, 32'h0);

    t4_m1_re = 1'b1; t4_m1_addr = 32'hE000_0000;
    tick();
    clearStrobes();
    checkOutput("t4 to b_re", t4_b_re, 1);
    n = 0;
    while (t4_m1_ack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("t4 to latency", n, 5);
    checkOutput("t4 to m1_err", t4_m1_err, 1);
    checkOutput("t4 to m1_rdata", t4_m1_rdata, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
